// File: rtl/timer_pkg.sv
// Shared definitions for the T0 programmable down-counter: FSM state
// encodings, register offsets, mode codes and the CTRL register layout.
package timer_pkg;

   // Counter sequencer states.
   typedef enum logic [1:0] {
      TM_IDLE = 2'b00,
      TM_LOAD = 2'b01,
      TM_CNT  = 2'b10,
      TM_INT  = 2'b11
   } tm_state_e;

   // Register offsets, decoded from addr[3:2].
   localparam logic [1:0] TM_CTRL   = 2'b00;
   localparam logic [1:0] TM_PRESET = 2'b01;
   localparam logic [1:0] TM_COUNT  = 2'b10;

   // Mode field encodings; codes 10/11 behave as one-shot.
   localparam logic [1:0] TM_MODE0 = 2'b00;
   localparam logic [1:0] TM_MODE1 = 2'b01;

   // CTRL[3:0] layout: bit3 IM, bits[2:1] Mode, bit0 Enable.
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       enable;
   } tm_ctrl_t;

   // Only mode 01 reloads automatically after expiry.
   function automatic logic tm_is_reload(input logic [1:0] mode);
      return mode == TM_MODE1;
   endfunction

endpackage

// File: rtl/timer_if.sv
// Bridge-side bus of the timer slot: word address, write strobe and data,
// combinational read data and the interrupt request toward CP0.
interface timer_if;

   logic [31:2] addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   // The system bus bridge drives the access and captures read data.
   modport master (
      output addr, we, din,
      input  dout, irq
   );

   // The timer decodes the access and returns data and interrupt.
   modport slave (
      input  addr, we, din,
      output dout, irq
   );

endinterface

// File: rtl/timer.sv
// Memory-mapped 32-bit down-counter with one-shot and auto-reload modes.
// Holds the CTRL/PRESET/COUNT register file, the IDLE/LOAD/CNT/INT
// sequencer and the combinational read mux in one flat module.
module timer
   import timer_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   timer_if.slave bus
);

   tm_state_e   r_state;
   tm_state_e   w_state_nxt;
   tm_ctrl_t    r_ctrl;
   tm_ctrl_t    w_ctrl_nxt;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic [31:0] w_count_nxt;
   logic        r_irq_flag;
   logic        w_irq_flag_nxt;
   logic        w_fsm_flag;
   logic        w_fsm_clr_en;
   logic [1:0]  w_off;
   logic        w_ctrl_wr;
   logic        w_preset_wr;
   logic [31:0] w_dout;
   logic        w_unused_addr;

   // Only addr[3:2] selects a register; the upper word-address bits belong
   // to the bridge's slot decode.
   assign w_off         = bus.addr[3:2];
   assign w_unused_addr = ^bus.addr[31:4];
   assign w_ctrl_wr     = bus.we && (w_off == TM_CTRL);
   assign w_preset_wr   = bus.we && (w_off == TM_PRESET);

   // Sequencer: next state, next COUNT and the FSM's view of the flag.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_fsm_flag   = r_irq_flag;
      w_fsm_clr_en = 1'b0;
      case (r_state)
         TM_IDLE: begin
            if (r_ctrl.enable) begin
               w_state_nxt = TM_LOAD;
            end
         end
         TM_LOAD: begin
            // PRESET is sampled from the register, so a write landing on
            // this same edge is picked up only by the next LOAD.
            w_count_nxt = r_preset;
            w_state_nxt = TM_CNT;
         end
         TM_CNT: begin
            if (!r_ctrl.enable) begin
               w_state_nxt = TM_IDLE;
            end else if (r_count > 32'd1) begin
               w_count_nxt = r_count - 32'd1;
            end else begin
               // COUNT of 0 or 1 both expire; the counter never wraps.
               w_count_nxt = '0;
               w_fsm_flag  = 1'b1;
               w_state_nxt = TM_INT;
            end
         end
         TM_INT: begin
            w_state_nxt = TM_IDLE;
            if (tm_is_reload(r_ctrl.mode)) begin
               // Enable stays set, so IDLE re-enters LOAD by itself.
               w_fsm_flag = 1'b0;
            end else begin
               // One-shot: the flag is held until software rewrites CTRL.
               w_fsm_clr_en = 1'b1;
            end
         end
         default: begin
            w_state_nxt = TM_IDLE;
         end
      endcase
   end

   // Merge CPU writes with FSM updates; a CTRL write always wins and clears the flag.
   always_comb begin
      w_ctrl_nxt     = r_ctrl;
      w_irq_flag_nxt = w_fsm_flag;
      if (w_ctrl_wr) begin
         w_ctrl_nxt     = tm_ctrl_t'(bus.din[3:0]);
         w_irq_flag_nxt = 1'b0;
      end else if (w_fsm_clr_en) begin
         w_ctrl_nxt.enable = 1'b0;
      end
   end

   // State and register file, synchronously reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         r_state    <= TM_IDLE;
         r_ctrl     <= '0;
         r_preset   <= '0;
         r_count    <= '0;
         r_irq_flag <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ctrl     <= w_ctrl_nxt;
         r_count    <= w_count_nxt;
         r_irq_flag <= w_irq_flag_nxt;
         if (w_preset_wr) begin
            r_preset <= bus.din;
         end
      end
   end

   // Zero-latency read mux; the unused offset and CTRL[31:4] read as zero.
   always_comb begin
      w_dout = '0;
      case (w_off)
         TM_CTRL:   w_dout = {28'd0, r_ctrl};
         TM_PRESET: w_dout = r_preset;
         TM_COUNT:  w_dout = r_count;
         default:   w_dout = '0;
      endcase
   end

   assign bus.dout = w_dout;
   assign bus.irq  = r_ctrl.im & r_irq_flag;

endmodule
